// File: rtl/fifo_pkg.sv
// fifo_pkg: constants and helpers shared by the async FIFO pointer handlers
// and the read-side stream consumer.
package fifo_pkg;

    // Supported range of the FIFO memory read latency
    localparam int unsigned RD_LATENCY_MIN = 1;
    localparam int unsigned RD_LATENCY_MAX = 2;

    // Pointer width for a power-of-2 depth: address bits plus one wrap bit
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port, downstream valid/ready stream and
// status signals of the read-side consumer.
interface fifo_rd_stream_if
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 4,
    parameter int unsigned CNT_WIDTH  = 32
);
    logic                              EN;
    logic                              EMPTY;
    logic                              R_EN;
    logic [DATA_WIDTH-1:0]             F_DATA;
    logic                              M_VALID;
    logic                              M_READY;
    logic [DATA_WIDTH-1:0]             M_DATA;
    logic [ptr_width(BUF_DEPTH)-1:0]   OCC;
    logic [CNT_WIDTH-1:0]              WORD_CNT;

    // Consumer block view
    modport master (
        input  EN, EMPTY, F_DATA, M_READY,
        output R_EN, M_VALID, M_DATA, OCC, WORD_CNT
    );

    // Environment view: FIFO, control and downstream sink
    modport slave (
        output EN, EMPTY, F_DATA, M_READY,
        input  R_EN, M_VALID, M_DATA, OCC, WORD_CNT
    );
endinterface

// File: rtl/fifo_rd_stream_skid_buf.sv
// stream_skid_buf: circular prefetch buffer with wrap-bit pointers.
// The head entry is presented directly; valid is derived from the
// registered pointers only, so there is no path from push_data to head.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic [DATA_WIDTH-1:0]         push_data,
    input  logic                          pop,
    output logic [DATA_WIDTH-1:0]         head,
    output logic                          valid,
    output logic [ptr_width(DEPTH)-1:0]   occ
);
    localparam int unsigned PW = ptr_width(DEPTH);
    localparam int unsigned AW = PW - 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  empty;
    logic                  full;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = push && !rst;
    assign do_pop  = pop && !empty && !rst;

    assign valid = !empty;
    assign head  = mem[rd_ptr[AW-1:0]];
    assign occ   = wr_ptr - rd_ptr;

    // Storage write; contents need no reset since valid gates the head
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    // Pointer update; capture and pop in the same cycle move both pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // The credit rule upstream must never let a write reach a full buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(push && full));
        end
    end

endmodule

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: read-side consumer of the async FIFO. Issues R_EN against
// EMPTY with a credit check, tracks reads in flight through the FIFO memory
// latency, lands them in a prefetch buffer and streams them out.
module fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned BUF_DEPTH  = 4,
    parameter int unsigned CNT_WIDTH  = 32
) (
    input  logic             R_CLK,
    input  logic             RRST,
    fifo_rd_stream_if.master bus
);
    localparam int unsigned OW = ptr_width(BUF_DEPTH);

    if (RD_LATENCY < RD_LATENCY_MIN || RD_LATENCY > RD_LATENCY_MAX) begin : g_bad_latency
        $error("fifo_rd_stream: RD_LATENCY must be 1 or 2");
    end
    if ((BUF_DEPTH & (BUF_DEPTH - 1)) != 0 || BUF_DEPTH < RD_LATENCY + 2) begin : g_bad_depth
        $error("fifo_rd_stream: BUF_DEPTH must be a power of 2 and >= RD_LATENCY+2");
    end

    logic [RD_LATENCY-1:0] inflight;
    logic [OW-1:0]         inflight_cnt;
    logic [OW-1:0]         occ;
    logic [OW:0]           committed;
    logic                  credit;
    logic                  r_en;
    logic                  push;
    logic                  pop;
    logic                  m_valid;
    logic [DATA_WIDTH-1:0] m_data;
    logic [CNT_WIDTH-1:0]  word_cnt;

    // Buffer slots already claimed: stored words plus reads still in the
    // memory pipeline. A same-cycle pop is deliberately not credited.
    assign inflight_cnt = OW'($countones(inflight));
    assign committed    = {1'b0, occ} + {1'b0, inflight_cnt};
    assign credit       = committed < (OW + 1)'(BUF_DEPTH);
    assign r_en         = bus.EN && !bus.EMPTY && !RRST && credit;

    assign push = inflight[RD_LATENCY-1] && !RRST;
    assign pop  = m_valid && bus.M_READY;

    // In-flight tracker: one bit per outstanding read, aged each edge
    always_ff @(posedge R_CLK) begin
        if (RRST) begin
            inflight <= '0;
        end else begin
            inflight[0] <= r_en;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                inflight[i] <= inflight[i-1];
            end
        end
    end

    // Completed-transfer counter, wraps naturally
    always_ff @(posedge R_CLK) begin
        if (RRST) begin
            word_cnt <= '0;
        end else if (pop) begin
            word_cnt <= word_cnt + CNT_WIDTH'(1);
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk       (R_CLK),
        .rst       (RRST),
        .push      (push),
        .push_data (bus.F_DATA),
        .pop       (pop),
        .head      (m_data),
        .valid     (m_valid),
        .occ       (occ)
    );

    assign bus.R_EN     = r_en;
    assign bus.M_VALID  = m_valid;
    assign bus.M_DATA   = m_data;
    assign bus.OCC      = occ;
    assign bus.WORD_CNT = word_cnt;

endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: two consumers (RD_LATENCY 1 and 2) driven by shared
// control stimulus, each fed by its own FIFO source model and compared every
// cycle against a queue-based reference of the stream behaviour.
module tb_fifo_rd_stream;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned NSRC  = 8192;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0;
    logic empty = 1'b1;
    logic m_ready = 1'b0;
    logic run_checks = 1'b0;

    int checks = 0;
    int failures = 0;
    int ren_count [2];

    logic [DW-1:0] src_mem [NSRC];

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_lane
        localparam int unsigned LAT = g + 1;
        localparam int unsigned CW  = (g == 0) ? 32 : 5;

        typedef struct {
            int unsigned   due;
            logic [DW-1:0] d;
        } rd_t;

        fifo_rd_stream_if #(.DATA_WIDTH(DW), .BUF_DEPTH(DEPTH), .CNT_WIDTH(CW)) bus ();

        fifo_rd_stream #(
            .DATA_WIDTH (DW),
            .RD_LATENCY (LAT),
            .BUF_DEPTH  (DEPTH),
            .CNT_WIDTH  (CW)
        ) u_dut (
            .R_CLK (clk),
            .RRST  (rst),
            .bus   (bus.master)
        );

        assign bus.EN      = en;
        assign bus.EMPTY   = empty;
        assign bus.M_READY = m_ready;

        // FIFO source: a sampled R_EN pops the next word, which appears on
        // F_DATA LAT edges later; otherwise the read port shows junk.
        logic [DW-1:0] pipe [LAT];
        int unsigned   src_idx = 0;
        always @(posedge clk) begin
            if (bus.R_EN) begin
                pipe[0] <= src_mem[src_idx % NSRC];
                src_idx <= src_idx + 1;
            end else begin
                pipe[0] <= DW'($urandom);
            end
            for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
        end
        assign bus.F_DATA = pipe[LAT-1];

        // Reference: words waiting in the memory pipeline and words buffered
        rd_t           pend [$];
        logic [DW-1:0] mq [$];
        int unsigned   cyc = 0;
        int unsigned   m_idx = 0;
        longint unsigned m_cnt = 0;

        function automatic logic exp_ren();
            return en && !empty && !rst && ((mq.size() + pend.size()) < DEPTH);
        endfunction

        always @(posedge clk) begin
            rd_t  e;
            logic r;
            r = exp_ren();
            if (rst) begin
                mq.delete();
                pend.delete();
                m_cnt = 0;
            end else begin
                if (mq.size() > 0 && m_ready) begin
                    void'(mq.pop_front());
                    m_cnt++;
                end
                if (pend.size() > 0 && pend[0].due == cyc) begin
                    e = pend.pop_front();
                    mq.push_back(e.d);
                end
                if (r) begin
                    e.due = cyc + LAT;
                    e.d   = src_mem[m_idx % NSRC];
                    pend.push_back(e);
                    m_idx++;
                end
            end
            cyc++;
        end

        always @(negedge clk) begin
            if (run_checks) begin
                check_val($sformatf("L%0d r_en", LAT), 64'(bus.R_EN), 64'(exp_ren()));
                check_val($sformatf("L%0d m_valid", LAT), 64'(bus.M_VALID), 64'(mq.size() > 0));
                if (mq.size() > 0)
                    check_val($sformatf("L%0d m_data", LAT), 64'(bus.M_DATA), 64'(mq[0]));
                check_val($sformatf("L%0d occ", LAT), 64'(bus.OCC), 64'(mq.size()));
                check_val($sformatf("L%0d word_cnt", LAT), 64'(bus.WORD_CNT),
                          m_cnt & ((64'd1 << CW) - 64'd1));
            end
        end

        always @(posedge clk) begin
            if (!rst && bus.R_EN) ren_count[g]++;
        end
    end

    task automatic drive(input logic e, input logic em, input logic rdy, input logic r);
        @(posedge clk);
        #1;
        en = e; empty = em; m_ready = rdy; rst = r;
    endtask

    initial begin
        foreach (src_mem[i]) src_mem[i] = DW'($urandom);
        ren_count[0] = 0;
        ren_count[1] = 0;

        // Reset, then free-flowing stream
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        run_checks = 1'b1;
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (20) drive(1'b1, 1'b0, 1'b1, 1'b0);

        // Stall from a clean state: the credit limit allows exactly DEPTH reads
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        ren_count[0] = 0;
        ren_count[1] = 0;
        repeat (20) drive(1'b1, 1'b0, 1'b0, 1'b0);
        check_val("L1 stall reads", 64'(ren_count[0]), 64'(DEPTH));
        check_val("L2 stall reads", 64'(ren_count[1]), 64'(DEPTH));
        repeat (20) drive(1'b1, 1'b0, 1'b1, 1'b0);

        // EMPTY toggling every cycle
        for (int i = 0; i < 40; i++) drive(1'b1, 1'(i % 2), 1'b1, 1'b0);

        // Reset while words are buffered and a read is in flight
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 1'b1);
        repeat (10) drive(1'b1, 1'b0, 1'b1, 1'b0);

        // Randomized traffic with occasional resets and EN drops
        for (int i = 0; i < 3000; i++) begin
            drive(1'($urandom_range(7) != 0), 1'($urandom_range(2) == 0),
                  1'($urandom_range(2) != 0), 1'($urandom_range(99) == 0));
        end

        // Drain with reads disabled
        repeat (20) drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        run_checks = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side consumer of the async FIFO, in the R_CLK domain.
- Issues R_EN against the FIFO's EMPTY flag.
- Absorbs the FIFO memory's fixed read latency through an in-flight tracker and a small prefetch buffer.
- Presents the data downstream as a valid/ready stream with full throughput, plus occupancy and transfer-count status.

Parameters:
- DATA_WIDTH, 8, width of FIFO data and stream data.
- RD_LATENCY, 1, R_CLK edges from a sampled R_EN to valid F_DATA. Legal values: 1 or 2.
- BUF_DEPTH, 4, prefetch buffer entries. Must be a power of 2 and ≥ RD_LATENCY+2.
- CNT_WIDTH, 32, width of the transfer counter.

Ports:
- R_CLK  in  1  read-domain clock; the only clock in the block.
- RRST  in  1  synchronous, active-high reset, sampled on R_CLK.
- EN  in  1  allows new FIFO reads. Buffered and in-flight words still drain when low.
- EMPTY  in  1  FIFO empty flag (already synchronous to R_CLK).
- R_EN  out  1  FIFO read enable.
- F_DATA  in  DATA_WIDTH  FIFO read data (FIFO O_DATA).
- M_VALID  out  1  stream data valid.
- M_READY  in  1  downstream accept.
- M_DATA  out  DATA_WIDTH  stream data (buffer head).
- OCC  out  $clog2(BUF_DEPTH)+1  prefetch buffer entries in use.
- WORD_CNT  out  CNT_WIDTH  count of completed stream transfers; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset (RRST high at a R_CLK edge):
  - in-flight shift register cleared, buffer pointers = 0, OCC = 0, WORD_CNT = 0, M_VALID = 0.
  - R_EN is forced 0 while RRST is high.
  - M_DATA content is don't-care.
- Reset mid-operation: in-flight reads are discarded; data returned by the FIFO after reset is ignored. The FIFO's own read pointer has already advanced, so those words are lost by design.
- R_EN (combinational) = EN & !EMPTY & !RRST & (OCC + INFLIGHT < BUF_DEPTH).
  - INFLIGHT = popcount of the in-flight shift register.
  - Credit check is conservative: it does not credit a same-cycle pop.
- In-flight tracker: RD_LATENCY-bit shift register.
  - Bit 0 is loaded with R_EN each edge.
  - The word is captured when the top bit shifts out: F_DATA is written to the buffer at the edge ending cycle t+RD_LATENCY, where t is the issue cycle.
- Buffer: circular, BUF_DEPTH entries, wr_ptr/rd_ptr with an extra wrap bit.
  - full = MSBs differ and LSBs equal; empty = pointers equal.
  - Overflow is impossible by the credit rule; assert on a write while full.
- M_VALID = !buffer_empty, registered state. M_DATA = mem[rd_ptr]. No combinational bypass from F_DATA.
  - First-word latency: R_EN at cycle t → M_VALID high in cycle t+RD_LATENCY+1.
- Pop: M_VALID & M_READY at an edge → rd_ptr+1 and WORD_CNT+1.
- Simultaneous capture and pop: OCC unchanged; both pointers advance.
- M_DATA/M_VALID stable while M_VALID & !M_READY (AXI-style: no retraction, no data change).
- Throughput: one word/cycle sustained when EMPTY=0 and M_READY=1, for the legal parameter range.
- EMPTY is sampled only through R_EN; the block never reads while EMPTY=1.
- EN deasserted: R_EN=0 from that cycle; in-flight words still land; buffer drains normally.

Decomposition:
- Package fifo_pkg: RD_LATENCY legal-range check constants and the ptr-width function (clog2 + wrap bit), shared with the FIFO pointer handlers.
- One natural sub-module, stream_skid_buf: circular buffer with OCC/full/empty and push/pop ports.
- Top holds the credit logic, in-flight tracker and WORD_CNT.

Test Plan:
- Reset, then EMPTY=0 with words 0x11,0x22,0x33 at RD_LATENCY=1, M_READY=1 → R_EN high from the first cycle after reset; M_VALID rises 2 cycles after the first R_EN; stream carries 0x11,0x22,0x33 on consecutive cycles; WORD_CNT=3.
- M_READY=0, EMPTY=0 continuously, BUF_DEPTH=4 → exactly 4 R_EN pulses; OCC reaches 4 and holds; M_DATA stable at the first word. Then M_READY=1 → 1 word/cycle, R_EN resumes the cycle after the first pop.
- EMPTY toggling 1/0 every cycle with M_READY=1 → no read while EMPTY=1; data order preserved; no duplicates or drops.
- RD_LATENCY=2, burst of 8 words (0x00–0x07), M_READY=1 → first M_VALID 3 cycles after first R_EN; 8 back-to-back transfers; WORD_CNT=8.
- RRST asserted for one cycle with OCC=2 and one read in flight → next cycle M_VALID=0, OCC=0, WORD_CNT=0; the late F_DATA word is not captured.
- WORD_CNT preloaded via force to 0xFFFFFFFF, then one transfer → WORD_CNT=0x00000000.
